cache_axi_arbiter: RTL and testbench
====================================

// Module: cache_axi_arbiter
// PURPOSE
//  Shares one AXI4 master port between the instruction cache (read-only miss refill) and the data cache
//  (single-word read/write). Grants one requester at a time, sequences the AR/R or AW/W/B channels,
//  and returns rdata plus a one-cycle dok strobe that the cache uses as its refill write enable.
//  Sits between the I/D caches and the SoC AXI interconnect; at most one outstanding transaction.
// PARAMETERS
//  ID_INST   4'd0  arid used for instruction fetches
//  ID_DATA   4'd1  arid/awid used for data accesses
// PORTS
//  clk               in   1   clock
//  resetn            in   1   synchronous active-low reset
//  inst_cache_req    in   1   I-cache miss request; held until inst_cache_dok
//  inst_cache_addr   in   32  fetch address (word aligned)
//  inst_cache_rdata  out  32  fetched word, valid when inst_cache_dok=1
//  inst_cache_dok    out  1   1-cycle completion strobe for I-cache
//  data_cache_req    in   1   D-cache request; req/wr/size/addr/wdata/wstrb held until data_cache_dok
//  data_cache_wr     in   1   1=write, 0=read
//  data_cache_size   in   2   0=byte 1=half 2=word -> arsize/awsize
//  data_cache_addr   in   32  byte address
//  data_cache_wdata  in   32  write data
//  data_cache_wstrb  in   4   byte enables
//  data_cache_rdata  out  32  read word, valid when data_cache_dok=1
//  data_cache_dok    out  1   1-cycle completion strobe (read data or write response)
//  arid/araddr/arlen/arsize/arvalid out 4/32/8/3/1; arready in 1   AXI read address
//  rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1; rready out 1         AXI read data
//  awid/awaddr/awlen/awsize/awvalid out 4/32/8/3/1; awready in 1   AXI write address
//  wdata/wstrb/wlast/wvalid out 32/4/1/1; wready in 1               AXI write data
//  bid/bresp/bvalid in 4/2/1; bready out 1                         AXI write response
// BEHAVIOUR
//  States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP. Reset (resetn=0 at posedge): state=IDLE,
//   all valid/ready outputs, dok strobes and grant = 0, from any state (mid-burst abort accepted).
//  IDLE: if data_cache_req -> grant DATA (fixed data priority); else if inst_cache_req -> grant INST.
//   Address/attributes captured into registers on the grant edge; go RD_ADDR (read) or WR_ADDR_DATA.
//  RD_ADDR: arvalid=1, araddr/arid/arsize from captured regs, arlen=0; INST uses arsize=2.
//   Stay until arready; then RD_DATA. arvalid drops the cycle after the handshake.
//  RD_DATA: rready=1. On rvalid&rlast: granted dok=1 that same cycle, *_rdata = AXI rdata
//   (combinational pass-through), -> IDLE. Non-granted dok stays 0; its rdata is don't-care.
//  WR_ADDR_DATA: awvalid and wvalid raised together, awlen=0, wlast=1. Flags aw_done/w_done set on
//   each handshake; each valid drops once its own handshake occurs (either order or same cycle).
//   When both done -> WR_RESP.
//  WR_RESP: bready=1; on bvalid: data_cache_dok=1 for one cycle, -> IDLE.
//  rresp/bresp errors ignored: transaction completes and dok is still issued.
//  After any completion the FSM spends >=1 cycle in IDLE, so a cache whose req is combinational
//   on miss sees its refill written before re-arbitration; no back-to-back grant on the dok cycle.
//  No preemption: a request arriving while busy waits; INST can be delayed by continuous DATA
//   traffic (accepted: D-side stalls the pipeline anyway).
//  Requester dropping req mid-transaction is illegal; the transaction completes regardless.
// TESTING
//  I-miss only, addr=0xBFC00000, arready after 2 cycles, rdata=0x24080001 -> arid=0, arsize=2,
//   one inst_cache_dok pulse with rdata 0x24080001, data_cache_dok stays 0.
//  I and D req asserted same cycle (D read 0x80001000) -> D granted first, data_cache_dok, one IDLE
//   cycle, then I transaction issued with arid=0.
//  D write, size=0, wstrb=4'b0100, wready before awready -> wvalid drops first, awvalid held,
//   WR_RESP entered only after both; dok on bvalid cycle only.
//  D write with awready and wready in same cycle as raise, bresp=2'b10 -> dok still pulses once.
//  resetn=0 during RD_DATA -> next cycle all valids/ready/dok=0, state IDLE; new req granted normally.
//  rvalid held low 20 cycles -> rready stays 1, no dok, no new AR issued.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// Arbitrates one single-beat AXI4 master port between the I-cache (read refill) and the
// D-cache (single-word read/write); data side has fixed priority, one transaction in flight.
module cache_axi_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  input  logic        data_cache_req,
  input  logic        data_cache_wr,
  input  logic [1:0]  data_cache_size,
  input  logic [31:0] data_cache_addr,
  input  logic [31:0] data_cache_wdata,
  input  logic [3:0]  data_cache_wstrb,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4
  } state_t;

  state_t      state;
  logic        grant_data;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;

  // Handshake rule on every AXI channel: a beat transfers on a rising edge where valid and
  // ready are both high; a valid, once raised, is held with stable payload until that edge.
  logic r_fire, aw_fire, w_fire, b_fire;
  logic aw_done_nx, w_done_nx;

  assign r_fire     = (state == RD_DATA) && rready && rvalid && rlast;
  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  assign b_fire     = (state == WR_RESP) && bready && bvalid;
  assign aw_done_nx = aw_done || aw_fire;
  assign w_done_nx  = w_done || w_fire;

  // Response ids and error codes are not acted on; errored transfers still complete.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_data <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_cache_req) begin
            grant_data <= 1'b1;
            addr_q     <= data_cache_addr;
            size_q     <= data_cache_size;
            wdata_q    <= data_cache_wdata;
            wstrb_q    <= data_cache_wstrb;
            if (data_cache_wr) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_ADDR_DATA;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end else if (inst_cache_req) begin
            grant_data <= 1'b0;
            addr_q     <= inst_cache_addr;
            size_q     <= 2'd2;
            arvalid    <= 1'b1;
            state      <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_fire) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_ADDR_DATA: begin
          if (aw_fire) awvalid <= 1'b0;
          if (w_fire)  wvalid  <= 1'b0;
          if (aw_done_nx && w_done_nx) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
          end
        end
        WR_RESP: begin
          if (b_fire) begin
            bready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arid   = grant_data ? ID_DATA : ID_INST;
  assign araddr = addr_q;
  assign arlen  = 8'd0;
  assign arsize = {1'b0, size_q};
  assign awid   = ID_DATA;
  assign awaddr = addr_q;
  assign awlen  = 8'd0;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;

  // Strobes fire in the completing beat itself so the cache can write its refill that cycle.
  assign inst_cache_rdata = rdata;
  assign data_cache_rdata = rdata;
  assign inst_cache_dok   = r_fire && !grant_data;
  assign data_cache_dok   = (r_fire && grant_data) || b_fire;

  assign dbg_state = state;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Self-checking bench: the bench plays both caches and a randomized single-beat AXI slave,
// predicting grant order, AXI attributes and returned data from the request stream.
module tb_cache_axi_arbiter;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        data_cache_req;
  logic        data_cache_wr;
  logic [1:0]  data_cache_size;
  logic [31:0] data_cache_addr;
  logic [31:0] data_cache_wdata;
  logic [3:0]  data_cache_wstrb;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  cache_axi_arbiter #(.ID_INST(ID_INST), .ID_DATA(ID_DATA)) dut (
    .clk(clk), .resetn(resetn),
    .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
    .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
    .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
    .data_cache_size(data_cache_size), .data_cache_addr(data_cache_addr),
    .data_cache_wdata(data_cache_wdata), .data_cache_wstrb(data_cache_wstrb),
    .data_cache_rdata(data_cache_rdata), .data_cache_dok(data_cache_dok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // cache-side drivers, called at a falling edge
  task automatic issue_inst(input logic [31:0] addr);
    inst_cache_req  = 1'b1;
    inst_cache_addr = addr;
  endtask

  task automatic issue_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
    data_cache_req   = 1'b1;
    data_cache_wr    = wr;
    data_cache_size  = size;
    data_cache_addr  = addr;
    data_cache_wdata = wd;
    data_cache_wstrb = ws;
  endtask

  task automatic drop_req(input bit is_data);
    if (is_data) data_cache_req = 1'b0;
    else         inst_cache_req = 1'b0;
  endtask

  task automatic check_quiet_idle(input string tag);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_awvalid"}, awvalid, 1'b0);
    check({tag, "_idok"}, inst_cache_dok, 1'b0);
    check({tag, "_ddok"}, data_cache_dok, 1'b0);
  endtask

  // AXI slave for one read; abort=1 pulls reset once the AR beat has been taken
  task automatic serve_read(input bit is_data, input logic [31:0] addr, input logic [2:0] size,
                            input int ar_dly, input int r_dly, input logic [31:0] data,
                            input bit abort);
    int n;
    logic [31:0] exp_data;
    n = 0;
    while (!arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_raised", arvalid, 1'b1);
    if (!arvalid) return;
    check("araddr", araddr, addr);
    check("arid", arid, is_data ? ID_DATA : ID_INST);
    check("arsize", arsize, size);
    check("arlen", arlen, 8'd0);
    check("aw_quiet_on_read", awvalid, 1'b0);
    repeat (ar_dly) begin
      @(negedge clk);
      check("arvalid_hold", arvalid, 1'b1);
      check("rready_early", rready, 1'b0);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("arvalid_drop", arvalid, 1'b0);
    check("rready_up", rready, 1'b1);
    if (abort) begin
      resetn = 1'b0;
      drop_req(is_data);
      @(negedge clk);
      check("abort_rready", rready, 1'b0);
      check("abort_state", dbg_state, 3'd0);
      check("abort_bready", bready, 1'b0);
      check_quiet_idle("abort");
      resetn = 1'b1;
      return;
    end
    repeat (r_dly) begin
      #1;
      check("wait_idok", inst_cache_dok, 1'b0);
      check("wait_ddok", data_cache_dok, 1'b0);
      @(negedge clk);
      check("wait_rready", rready, 1'b1);
      check("wait_no_ar", arvalid, 1'b0);
    end
    rvalid = 1'b1;
    rlast  = 1'b1;
    rdata  = data;
    rresp  = 2'($urandom_range(0, 3));
    rid    = is_data ? ID_DATA : ID_INST;
    exp_q.push_back(data);
    #1;
    exp_data = exp_q.pop_front();
    check("r_idok", inst_cache_dok, !is_data);
    check("r_ddok", data_cache_dok, is_data);
    if (is_data) check("d_rdata", data_cache_rdata, exp_data);
    else         check("i_rdata", inst_cache_rdata, exp_data);
    @(negedge clk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = $urandom;
    drop_req(is_data);
    #1;
    check("post_r_rready", rready, 1'b0);
    check_quiet_idle("post_r");
  endtask

  // AXI slave for one write; aw/w readies arrive after independent delays
  task automatic serve_write(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp);
    int n;
    int cyc;
    bit aw_done;
    bit w_done;
    n = 0;
    while (!awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("aw_raised", awvalid, 1'b1);
    if (!awvalid) return;
    check("w_raised", wvalid, 1'b1);
    check("awaddr", awaddr, addr);
    check("awid", awid, ID_DATA);
    check("awsize", awsize, size);
    check("awlen", awlen, 8'd0);
    check("wdata", wdata, wd);
    check("wstrb", wstrb, ws);
    check("wlast", wlast, 1'b1);
    check("ar_quiet_on_write", arvalid, 1'b0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc = 0;
    while (!(aw_done && w_done)) begin
      awready = !aw_done && (cyc >= aw_dly);
      wready  = !w_done && (cyc >= w_dly);
      #1;
      check("wr_ddok_early", data_cache_dok, 1'b0);
      @(negedge clk);
      if (awready) aw_done = 1'b1;
      if (wready)  w_done  = 1'b1;
      awready = 1'b0;
      wready  = 1'b0;
      cyc++;
      check("awvalid_track", awvalid, !aw_done);
      check("wvalid_track", wvalid, !w_done);
      check("bready_track", bready, aw_done && w_done);
    end
    repeat (b_dly) begin
      #1;
      check("bwait_ddok", data_cache_dok, 1'b0);
      @(negedge clk);
      check("bwait_bready", bready, 1'b1);
    end
    bvalid = 1'b1;
    bresp  = resp;
    bid    = ID_DATA;
    #1;
    check("b_ddok", data_cache_dok, 1'b1);
    check("b_idok", inst_cache_dok, 1'b0);
    @(negedge clk);
    bvalid = 1'b0;
    drop_req(1'b1);
    #1;
    check("post_b_bready", bready, 1'b0);
    check_quiet_idle("post_b");
  endtask

  initial begin
    int mode;
    logic [31:0] ia, da, dwd;
    logic [1:0]  dsz;
    logic [3:0]  dws;

    // clock/reset block
    resetn = 1'b0;
    inst_cache_req = 1'b0; inst_cache_addr = '0;
    data_cache_req = 1'b0; data_cache_wr = 1'b0; data_cache_size = '0;
    data_cache_addr = '0; data_cache_wdata = '0; data_cache_wstrb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, 3'd0);
    check("rst_rready", rready, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check_quiet_idle("rst");
    resetn = 1'b1;
    @(negedge clk);

    // instruction miss alone
    issue_inst(32'hBFC0_0000);
    serve_read(1'b0, 32'hBFC0_0000, 3'd2, 2, 1, 32'h2408_0001, 1'b0);
    @(negedge clk);

    // simultaneous requests: data wins, then instruction after an idle cycle
    issue_inst(32'hBFC0_0010);
    issue_data(1'b0, 2'd2, 32'h8000_1000, '0, 4'hF);
    serve_read(1'b1, 32'h8000_1000, 3'd2, 0, 0, 32'hCAFE_0001, 1'b0);
    serve_read(1'b0, 32'hBFC0_0010, 3'd2, 1, 0, 32'h0000_0013, 1'b0);

    // byte write, W accepted before AW
    issue_data(1'b1, 2'd0, 32'h8000_2002, 32'h00AB_0000, 4'b0100);
    serve_write(32'h8000_2002, 3'd0, 32'h00AB_0000, 4'b0100, 3, 0, 2, 2'b00);

    // both readies at once, error response still completes
    issue_data(1'b1, 2'd2, 32'h8000_3000, 32'h1234_5678, 4'hF);
    serve_write(32'h8000_3000, 3'd2, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b10);

    // reset in the data phase, then a normal data read
    issue_inst(32'hBFC0_0100);
    serve_read(1'b0, 32'hBFC0_0100, 3'd2, 0, 0, '0, 1'b1);
    issue_data(1'b0, 2'd1, 32'h8000_4002, '0, 4'b1100);
    serve_read(1'b1, 32'h8000_4002, 3'd1, 1, 0, 32'h0000_BEEF, 1'b0);

    // long read-data stall
    issue_inst(32'hBFC0_0200);
    serve_read(1'b0, 32'hBFC0_0200, 3'd2, 0, 20, 32'h0BAD_F00D, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 4);
      ia   = $urandom & 32'hFFFF_FFFC;
      da   = $urandom;
      dsz  = 2'($urandom_range(0, 2));
      dwd  = $urandom;
      dws  = 4'($urandom_range(1, 15));
      case (mode)
        0: begin
          issue_inst(ia);
          serve_read(1'b0, ia, 3'd2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        1: begin
          issue_data(1'b0, dsz, da, dwd, dws);
          serve_read(1'b1, da, {1'b0, dsz}, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        2: begin
          issue_data(1'b1, dsz, da, dwd, dws);
          serve_write(da, {1'b0, dsz}, dwd, dws, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 2'($urandom_range(0, 3)));
        end
        3: begin
          issue_inst(ia);
          issue_data(1'b0, dsz, da, dwd, dws);
          serve_read(1'b1, da, {1'b0, dsz}, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
          serve_read(1'b0, ia, 3'd2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        default: begin
          issue_inst(ia);
          issue_data(1'b1, dsz, da, dwd, dws);
          serve_write(da, {1'b0, dsz}, dwd, dws, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 2'($urandom_range(0, 3)));
          serve_read(1'b0, ia, 3'd2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule
